// File: rtl/char_seg_pkg.sv
// Shared 7-segment character font and reader FSM encoding.
// The font is the same table the 5-bit character encoder implements.
package char_seg_pkg;

    localparam int         CODE_W    = 5;
    localparam int         SEG_W     = 7;
    localparam int         FONT_N    = 32;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segments {a,b,c,d,e,f,g}, a = bit 6. Entry 26 ('S') deliberately repeats '5'.
    localparam logic [6:0] CHAR_FONT [0:31] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
        7'h5E, 7'h37, 7'h06, 7'h3C, 7'h0E, 7'h15, 7'h1D, 7'h67,
        7'h73, 7'h05, 7'h5B, 7'h0F, 7'h3E, 7'h3B, 7'h01, 7'h08
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOOKUP = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/seg_font_rom.sv
// Combinational reverse font lookup: segment pattern -> {hit, code}.
// The lowest matching font index wins when the table holds duplicates.
module seg_font_rom
    import char_seg_pkg::*;
(
    input  logic [SEG_W-1:0]  seg_i,
    output logic              hit_o,
    output logic [CODE_W-1:0] code_o
);

    // Descending scan: the last match written is the lowest index.
    always_comb begin
        hit_o  = 1'b0;
        code_o = '0;
        for (int i = FONT_N - 1; i >= 0; i--) begin
            if (seg_i == CHAR_FONT[i]) begin
                hit_o  = 1'b1;
                code_o = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_char_reader.sv
// Debounces a 7-segment pattern, decodes it through the font table and
// offers the character code over valid/ready with character-change semantics.
module seg7_char_reader
    import char_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DROP_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    output logic [4:0]        code_out,
    output logic              code_err,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [SEG_W-1:0]    cap_q, cap_d;
    logic [SEG_W-1:0]    last_q, last_d;
    logic [SEG_W-1:0]    prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic                busy_q;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                rom_hit;
    logic [CODE_W-1:0]   rom_code;
    logic                drop_evt;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    seg_font_rom u_rom (
        .seg_i  (cap_q),
        .hit_o  (rom_hit),
        .code_o (rom_code)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (seg_in != last_q) begin
                    cap_d   = seg_in;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (seg_in != cap_q) begin
                    cap_d = seg_in;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A settled blank re-arms repeat detection without emitting anything.
                    if (cap_q == SEG_BLANK) begin
                        last_d  = SEG_BLANK;
                        state_d = IDLE;
                    end else begin
                        state_d = LOOKUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOOKUP: begin
                code_d  = rom_hit ? rom_code : '0;
                err_d   = ~rom_hit;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && code_ready) begin
                    valid_d = 1'b0;
                    last_d  = cap_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // prev_q holds cap on the first HOLD cycle so a change during LOOKUP is still counted.
    assign drop_evt = (state_q == HOLD) && (seg_in != cap_q) && (seg_in != prev_q);
    assign drop_d   = drop_evt ? sat_inc(drop_q) : drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            last_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            prev_q  <= (state_q == HOLD) ? seg_in : cap_q;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
            drop_q  <= drop_d;
        end
    end

    assign code_out   = code_q;
    assign code_err   = err_q;
    assign code_valid = valid_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_seg7_char_reader.sv
// Scoreboard bench for seg7_char_reader: expected {err,code} queued at stimulus, popped on handshake.
module tb_seg7_char_reader;
    import char_seg_pkg::*;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [4:0] code_out;
    logic       code_err;
    logic       code_valid;
    logic       code_ready;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [5:0] sb [$];

    always #5 clk = ~clk;

    seg7_char_reader #(.STABLE_CYCLES(SC), .DROP_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .code_out   (code_out),
        .code_err   (code_err),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    // Handshake monitor: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && code_valid && code_ready) begin
            logic [5:0] e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got err=%0b code=%0d, none expected", code_err, code_out);
            end else begin
                e = sb.pop_front();
                if ({code_err, code_out} !== e) begin
                    failures++;
                    $display("FAIL handshake got err=%0b code=%0d, expected err=%0b code=%0d",
                             code_err, code_out, e[5], e[4:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seg_in = 7'h00; code_ready = 1'b1;
        tick(2);
        checks++;
        if ({code_valid, code_err, code_out, busy, drop_cnt} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b err=%0b code=%0d busy=%0b drop=%0d, expected all 0",
                     code_valid, code_err, code_out, busy, drop_cnt);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || code_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0b valid=%0b, expected 0/0", busy, code_valid);
        end
    endtask

    task automatic test_latency();
        seg_in = CHAR_FONT[3];
        sb.push_back({1'b0, 5'd3});
        for (int k = 1; k <= SC + 1; k++) begin
            tick(1);
            checks++;
            if (code_valid !== 1'b0) begin
                failures++;
                $display("FAIL t1_early_valid tick=%0d got valid=%0b, expected 0", k, code_valid);
            end
        end
        tick(1);
        checks++;
        if (code_valid !== 1'b1 || code_out !== 5'd3 || code_err !== 1'b0) begin
            failures++;
            $display("FAIL t1_latency got valid=%0b code=%0d err=%0b, expected 1/3/0", code_valid, code_out, code_err);
        end
        tick(1);
        checks++;
        if (code_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_single_cycle got valid=%0b, expected 0", code_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t1_drain got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_glitch();
        int early = 0;
        for (int k = 0; k < 20; k++) begin
            seg_in = ((k / 2) % 2 == 0) ? CHAR_FONT[1] : CHAR_FONT[2];
            tick(1);
            if (code_valid) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL t2_glitch_output got valid_cycles=%0d, expected 0", early);
        end
        seg_in = CHAR_FONT[2];
        sb.push_back({1'b0, 5'd2});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t2_timeout got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        code_ready = 1'b0;
        seg_in = CHAR_FONT[7];
        sb.push_back({1'b0, 5'd7});
        for (int i = 0; i < 20 && !code_valid; i++) tick(1);
        checks++;
        if (code_valid !== 1'b1) begin
            failures++;
            $display("FAIL t3_valid_timeout got valid=%0b, expected 1", code_valid);
        end
        seg_in = CHAR_FONT[9];
        tick(3);
        seg_in = CHAR_FONT[10];
        tick(3);
        checks++;
        if (code_valid !== 1'b1 || code_out !== 5'd7) begin
            failures++;
            $display("FAIL t3_hold got valid=%0b code=%0d, expected 1/7", code_valid, code_out);
        end
        checks++;
        if (drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL t3_drop_cnt got %0d, expected 2", drop_cnt);
        end
        sb.push_back({1'b0, 5'd10});
        code_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t3_timeout got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_repeat_blank();
        int extra = 0;
        seg_in = CHAR_FONT[4];
        sb.push_back({1'b0, 5'd4});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (code_valid) extra++;
        end
        checks++;
        if (extra != 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL t4_repeat got valid_cycles=%0d pending=%0d, expected 0/0", extra, sb.size());
        end
        seg_in = SEG_BLANK;
        tick(6);
        seg_in = CHAR_FONT[4];
        sb.push_back({1'b0, 5'd4});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t4_after_blank got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_miss();
        logic [6:0] miss = 7'h00;
        for (int p = 1; p < 128; p++) begin
            logic [6:0] pv;
            logic found;
            pv = 7'(p);
            found = 1'b0;
            for (int i = 0; i < 32; i++) if (CHAR_FONT[i] == pv) found = 1'b1;
            if (!found && miss == 7'h00) miss = pv;
        end
        seg_in = miss;
        sb.push_back({1'b1, 5'd0});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t5_miss_timeout got pending=%0d, expected 0", sb.size());
        end
        // Entry 26 duplicates entry 5: the lower code must be reported.
        seg_in = CHAR_FONT[26];
        sb.push_back({1'b0, 5'd5});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t5_dup_timeout got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midop();
        seg_in = CHAR_FONT[6];
        tick(2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL t6_settle_busy got %0b, expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({code_valid, busy, drop_cnt} !== 10'h0) begin
            failures++;
            $display("FAIL t6_async_settle got valid=%0b busy=%0b drop=%0d, expected 0", code_valid, busy, drop_cnt);
        end
        tick(1);
        rst_n = 1'b1;
        sb.push_back({1'b0, 5'd6});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        tick(15);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t6_refilter got pending=%0d, expected 0", sb.size());
        end
        code_ready = 1'b0;
        seg_in = CHAR_FONT[8];
        for (int i = 0; i < 20 && !code_valid; i++) tick(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({code_valid, busy, code_out, code_err} !== 8'h0) begin
            failures++;
            $display("FAIL t6_async_hold got valid=%0b busy=%0b code=%0d err=%0b, expected 0",
                     code_valid, busy, code_out, code_err);
        end
        code_ready = 1'b1;
        tick(1);
        rst_n = 1'b1;
        sb.push_back({1'b0, 5'd8});
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        tick(15);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL t6_hold_reemit got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_drop_saturate();
        code_ready = 1'b0;
        seg_in = CHAR_FONT[11];
        sb.push_back({1'b0, 5'd11});
        for (int i = 0; i < 20 && !code_valid; i++) tick(1);
        for (int k = 0; k < 100; k++) begin
            seg_in = (k % 2 == 0) ? CHAR_FONT[12] : CHAR_FONT[13];
            tick(1);
        end
        checks++;
        if (drop_cnt !== 8'd100) begin
            failures++;
            $display("FAIL drop_count got %0d, expected 100", drop_cnt);
        end
        for (int k = 0; k < 200; k++) begin
            seg_in = (k % 2 == 0) ? CHAR_FONT[12] : CHAR_FONT[13];
            tick(1);
        end
        checks++;
        if (drop_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL drop_saturate got %0d, expected 255", drop_cnt);
        end
        seg_in = CHAR_FONT[11];
        tick(1);
        code_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0 || drop_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL drop_release got pending=%0d drop=%0d, expected 0/255", sb.size(), drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_backpressure();
        test_repeat_blank();
        test_miss();
        test_reset_midop();
        test_drop_saturate();
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
